// File: rtl/fetch_decode_unit_pkg.sv
// Shared constants for the fetch/decode unit: opcodes, FSM encoding, control strobe indices.
package fdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DECODE  = 2'b10,
    ST_EXECUTE = 2'b11
  } fdu_state_e;

  localparam logic [3:0] OP_LD_A      = 4'b0000;
  localparam logic [3:0] OP_LD_B      = 4'b0001;
  localparam logic [3:0] OP_LD_O      = 4'b0010;
  localparam logic [3:0] OP_LD_SH_A   = 4'b0011;
  localparam logic [3:0] OP_LD_SH_B   = 4'b0100;
  localparam logic [3:0] OP_SHR       = 4'b0101;
  localparam logic [3:0] OP_SHL       = 4'b0110;
  localparam logic [3:0] OP_ACC_NZ_A  = 4'b0111;
  localparam logic [3:0] OP_ACC_NZ_SH = 4'b1000;
  localparam logic [3:0] OP_CLR_ACC   = 4'b1111;

  localparam int CTRL_W = 10;

  localparam int CTRL_LD_A      = 0;
  localparam int CTRL_LD_B      = 1;
  localparam int CTRL_LD_O      = 2;
  localparam int CTRL_LD_SH_A   = 3;
  localparam int CTRL_LD_SH_B   = 4;
  localparam int CTRL_SHR       = 5;
  localparam int CTRL_SHL       = 6;
  localparam int CTRL_ACC_NZ_A  = 7;
  localparam int CTRL_ACC_NZ_SH = 8;
  localparam int CTRL_CLR_ACC   = 9;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bundle between the fetch/decode unit (master) and its ROM/datapath environment (slave).
interface fdu_if
  import fdu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 4
);

  logic                run;
  logic                step_mode;
  logic                step;
  logic                ex_busy;
  logic [INSTR_W-1:0]  rom_instr;
  logic [ADDR_W-1:0]   rom_addr;
  logic [CTRL_W-1:0]   ctrl;
  logic [1:0]          state;
  logic                pc_wrap;

  modport master (
    input  run, step_mode, step, ex_busy, rom_instr,
    output rom_addr, ctrl, state, pc_wrap
  );

  modport slave (
    output run, step_mode, step, ex_busy, rom_instr,
    input  rom_addr, ctrl, state, pc_wrap
  );

endinterface

// File: rtl/fetch_decode_unit_decoder.sv
// Combinational opcode decoder: one strobe per defined opcode, unused opcodes decode to all-zero.
module instr_decoder
  import fdu_pkg::*;
#(
  parameter int INSTR_W = 4
) (
  input  logic [INSTR_W-1:0] opcode_i,
  output logic [CTRL_W-1:0]  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      INSTR_W'(OP_LD_A):      ctrl_o[CTRL_LD_A]      = 1'b1;
      INSTR_W'(OP_LD_B):      ctrl_o[CTRL_LD_B]      = 1'b1;
      INSTR_W'(OP_LD_O):      ctrl_o[CTRL_LD_O]      = 1'b1;
      INSTR_W'(OP_LD_SH_A):   ctrl_o[CTRL_LD_SH_A]   = 1'b1;
      INSTR_W'(OP_LD_SH_B):   ctrl_o[CTRL_LD_SH_B]   = 1'b1;
      INSTR_W'(OP_SHR):       ctrl_o[CTRL_SHR]       = 1'b1;
      INSTR_W'(OP_SHL):       ctrl_o[CTRL_SHL]       = 1'b1;
      INSTR_W'(OP_ACC_NZ_A):  ctrl_o[CTRL_ACC_NZ_A]  = 1'b1;
      INSTR_W'(OP_ACC_NZ_SH): ctrl_o[CTRL_ACC_NZ_SH] = 1'b1;
      INSTR_W'(OP_CLR_ACC):   ctrl_o[CTRL_CLR_ACC]   = 1'b1;
      default:                ctrl_o                 = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode sequencer: PC, instruction register, control strobe register and the 4-state FSM.
//   state   | meaning
//   IDLE    | waiting for run (and a step pulse in step mode)
//   FETCH   | ROM addressed by PC, IR loads on exit
//   DECODE  | IR decoded, ctrl strobe loads on exit
//   EXECUTE | strobe for one cycle, held while ex_busy, PC advances on exit
module fetch_decode_unit
  import fdu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  fdu_if.master bus
);

  fdu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic                wrap_q, wrap_d;

  instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .opcode_i (ir_q),
    .ctrl_o   (dec_ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ctrl_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      wrap_q  <= wrap_d;
    end
  end

  // ctrl_d and wrap_d default to zero so both are single-cycle pulses.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ctrl_d  = '0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run && (!bus.step_mode || bus.step)) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = bus.rom_instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl_d  = dec_ctrl;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (!bus.ex_busy) begin
          pc_d    = pc_q + ADDR_W'(1);
          wrap_d  = &pc_q;
          state_d = (bus.run && !bus.step_mode) ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rom_addr = pc_q;
  assign bus.ctrl     = ctrl_q;
  assign bus.state    = state_q;
  assign bus.pc_wrap  = wrap_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench with a strobe scoreboard: stimulus pushes expected strobes, a monitor pops and checks them.
module tb_fetch_decode_unit;
  import fdu_pkg::*;

  typedef struct packed {
    logic [9:0] ctrl;
    logic [4:0] addr;
  } exp_t;

  logic clk;
  logic rst_n;
  logic force_nop;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  logic [3:0] prog [10] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0010,
                            4'b0011, 4'b0110, 4'b0111, 4'b1000, 4'b1111};

  fdu_if #(.ADDR_W(5), .INSTR_W(4)) bus ();

  fetch_decode_unit #(.ADDR_W(5), .INSTR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_instr = force_nop ? 4'b1010 : prog[int'(bus.rom_addr) % 10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] exp_ctrl(input logic [3:0] op);
    case (op)
      4'b0000: return 10'b00_0000_0001;
      4'b0001: return 10'b00_0000_0010;
      4'b0010: return 10'b00_0000_0100;
      4'b0011: return 10'b00_0000_1000;
      4'b0100: return 10'b00_0001_0000;
      4'b0101: return 10'b00_0010_0000;
      4'b0110: return 10'b00_0100_0000;
      4'b0111: return 10'b00_1000_0000;
      4'b1000: return 10'b01_0000_0000;
      4'b1111: return 10'b10_0000_0000;
      default: return 10'b00_0000_0000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_instr(input int addr);
    exp_t e;
    e.addr = 5'(addr);
    e.ctrl = exp_ctrl(prog[addr % 10]);
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_pulse();
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int n = 0;
    while (bus.state !== s && n < 20) begin
      tick(1);
      n++;
    end
    check(nm, 32'(bus.state), 32'(s));
  endtask

  // Scoreboard monitor: every nonzero ctrl must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.ctrl !== 10'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'(bus.ctrl), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_ctrl", 32'(bus.ctrl), 32'(e.ctrl));
        check("strobe_addr", 32'(bus.rom_addr), 32'(e.addr));
        check("strobe_state", 32'(bus.state), 32'(ST_EXECUTE));
      end
    end
  end

  initial begin
    int wraps;
    int wrap_cyc;
    n_checks      = 0;
    n_fail        = 0;
    force_nop     = 1'b0;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
    bus.ex_busy   = 1'b0;

    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_addr", 32'(bus.rom_addr), 0);
    check("rst_ctrl", 32'(bus.ctrl), 0);
    check("rst_wrap", 32'(bus.pc_wrap), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Free run across the PC wrap; run drops during the FETCH of the 33rd instruction.
    for (int i = 0; i < 33; i++) push_instr(i % 32);
    bus.run  = 1'b1;
    wraps    = 0;
    wrap_cyc = 0;
    for (int c = 1; c <= 99; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.pc_wrap === 1'b1) begin
        wraps++;
        wrap_cyc = c;
      end
      if (c == 3) check("cyc3_ld_a", 32'(bus.ctrl), 32'h001);
      if (c == 6) check("cyc6_ld_b", 32'(bus.ctrl), 32'h002);
      if (c == 9) check("cyc9_ld_sh_b", 32'(bus.ctrl), 32'h010);
      if (c == 97) begin
        check("wrap_addr", 32'(bus.rom_addr), 0);
        bus.run = 1'b0;
      end
      if (c == 99) check("cyc99_ld_a", 32'(bus.ctrl), 32'h001);
    end
    check("wrap_count", 32'(wraps), 1);
    check("wrap_cycle", 32'(wrap_cyc), 97);
    tick(3);
    check("run_off_state", 32'(bus.state), 32'(ST_IDLE));
    check("run_off_addr", 32'(bus.rom_addr), 1);
    check("run_off_sb_empty", 32'(sb_q.size()), 0);

    // Single-step mode with an extra step held into FETCH.
    @(negedge clk);
    rst_n = 1'b0;
    tick(1);
    rst_n         = 1'b1;
    bus.step_mode = 1'b1;
    bus.run       = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) push_instr(i);
    bus.step = 1'b1;
    tick(1);
    check("step_fetch_state", 32'(bus.state), 32'(ST_FETCH));
    tick(1);
    bus.step = 1'b0;
    tick(8);
    check("step1_idle", 32'(bus.state), 32'(ST_IDLE));
    check("step1_addr", 32'(bus.rom_addr), 1);
    for (int s = 0; s < 2; s++) begin
      step_pulse();
      tick(9);
      check("stepn_idle", 32'(bus.state), 32'(ST_IDLE));
    end
    check("step_pc3", 32'(bus.rom_addr), 3);
    check("step_sb_empty", 32'(sb_q.size()), 0);

    // SHR at address 3 with two busy cycles.
    push_instr(3);
    step_pulse();
    wait_state(2'(ST_EXECUTE), "busy_enter_exec");
    bus.ex_busy = 1'b1;
    tick(1);
    check("busy1_state", 32'(bus.state), 32'(ST_EXECUTE));
    check("busy1_ctrl", 32'(bus.ctrl), 0);
    check("busy1_pc", 32'(bus.rom_addr), 3);
    tick(1);
    check("busy2_state", 32'(bus.state), 32'(ST_EXECUTE));
    check("busy2_ctrl", 32'(bus.ctrl), 0);
    bus.ex_busy = 1'b0;
    tick(1);
    check("busy_exit_state", 32'(bus.state), 32'(ST_IDLE));
    check("busy_exit_pc", 32'(bus.rom_addr), 4);

    // Undefined opcode: no strobe, PC still advances.
    force_nop = 1'b1;
    step_pulse();
    tick(6);
    check("nop_pc", 32'(bus.rom_addr), 5);
    check("nop_state", 32'(bus.state), 32'(ST_IDLE));
    force_nop = 1'b0;

    // Reset during DECODE of address 5.
    step_pulse();
    wait_state(2'(ST_DECODE), "rst_mid_decode");
    check("rst_mid_addr_before", 32'(bus.rom_addr), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_mid_addr", 32'(bus.rom_addr), 0);
    check("rst_mid_ctrl", 32'(bus.ctrl), 0);
    check("rst_mid_wrap", 32'(bus.pc_wrap), 0);
    tick(2);
    check("rst_hold_ctrl", 32'(bus.ctrl), 0);
    rst_n = 1'b1;
    tick(1);
    push_instr(0);
    step_pulse();
    wait_state(2'(ST_FETCH), "post_rst_fetch");
    check("post_rst_addr", 32'(bus.rom_addr), 0);
    tick(6);
    check("post_rst_pc", 32'(bus.rom_addr), 1);
    check("final_sb_empty", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
